// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the initiator FSM state encoding.
// The SRAM-side responder imports the same response codes.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWr,
    StWrResp,
    StResp
  } axi_mst_state_e;

endpackage

// File: rtl/axi4lite_master_if.sv
// AXI4-Lite bus bundle (AR/R/AW/W/B) with initiator and responder views.
interface axi4lite_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                      arvalid;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic                      arready;

  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rready;

  logic                      awvalid;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      awready;

  logic                      wvalid;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wready;

  logic                      bvalid;
  logic [1:0]                bresp;
  logic                      bready;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator: bridges a single-outstanding CPU request/response port onto
// an AXI4-Lite bus. One transaction in flight; AW and W launch together and retire
// independently. All bus-facing valids/readies and the response are registered.
// Optional feature macro: AXI4L_MST_ALIGN_CHECK_EN (reject misaligned requests locally
// with SLVERR instead of issuing them on the bus).
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,

  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]              resp_code,

  axi4lite_master_if.master       bus
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;

  axi_mst_state_e          r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [StrbW-1:0]        r_wstrb;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic [1:0]              r_resp_code;

  logic                    w_req_fire;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_misaligned;

  // Idle is only advertised while out of reset so a request can't slip in during reset.
  assign req_ready  = (r_state == StIdle) && !rst;
  assign w_req_fire = req_valid && req_ready;
  assign w_aw_hs    = r_awvalid && bus.awready;
  assign w_w_hs     = r_wvalid && bus.wready;

`ifdef AXI4L_MST_ALIGN_CHECK_EN
  logic [2*StrbW-1:0] w_strb_shift;
  logic               w_strb_fits;

  // Strobe shifted by the byte offset must not spill past the aligned word.
  always_comb begin
    w_strb_shift = {{StrbW{1'b0}}, req_wstrb} << req_addr[1:0];
    w_strb_fits  = (w_strb_shift[2*StrbW-1:StrbW] == '0);
    w_misaligned = (req_addr[1:0] != 2'b00) && (!req_wen || !w_strb_fits);
  end
`else
  assign w_misaligned = 1'b0;
`endif

  assign bus.arvalid = r_arvalid;
  assign bus.araddr  = r_addr;
  assign bus.rready  = r_rready;
  assign bus.awvalid = r_awvalid;
  assign bus.awaddr  = r_addr;
  assign bus.wvalid  = r_wvalid;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = r_wstrb;
  assign bus.bready  = r_bready;

  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_code   = r_resp_code;

  // Transaction FSM with registered bus handshakes and registered CPU response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_code  <= RESP_OKAY;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req_fire) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            if (w_misaligned) begin
              // Rejected locally: no bus traffic at all.
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_code  <= RESP_SLVERR;
              r_state      <= StResp;
            end else if (req_wen) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= StWr;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= StRdAddr;
            end
          end
        end

        StRdAddr: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRdData;
          end
        end

        StRdData: begin
          if (bus.rvalid) begin
            r_rready     <= 1'b0;
            r_resp_rdata <= bus.rdata;
            r_resp_code  <= bus.rresp;
            r_resp_valid <= 1'b1;
            r_state      <= StResp;
          end
        end

        StWr: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Include this cycle's handshakes so simultaneous completion advances at once.
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_bready <= 1'b1;
            r_state  <= StWrResp;
          end
        end

        StWrResp: begin
          if (bus.bvalid) begin
            r_bready     <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_code  <= bus.bresp;
            r_resp_valid <= 1'b1;
            r_state      <= StResp;
          end
        end

        StResp: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= StIdle;
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master: table of single transactions against a
// zero-wait responder, plus cycle-exact sequences for ordering, back-pressure,
// reset and alignment corner cases. Honours AXI4L_MST_ALIGN_CHECK_EN.
module tb_axi4lite_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_code;

  int n_vec;
  int n_fail;

  int          ar_cnt, aw_cnt, w_cnt;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;

  axi4lite_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  axi4lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_code  (resp_code),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor on the bus.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.arvalid && bus.arready) begin
        ar_cnt      <= ar_cnt + 1;
        last_araddr <= bus.araddr;
      end
      if (bus.awvalid && bus.awready) begin
        aw_cnt      <= aw_cnt + 1;
        last_awaddr <= bus.awaddr;
      end
      if (bus.wvalid && bus.wready) begin
        w_cnt      <= w_cnt + 1;
        last_wdata <= bus.wdata;
        last_wstrb <= bus.wstrb;
      end
    end
  end

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    check("req_ready_before_accept", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic accept_resp();
    resp_ready = 1'b1;
    check("req_ready_in_accept_cycle", req_ready, 1'b0);
    tick();
    resp_ready = 1'b0;
    check("req_ready_after_accept", req_ready, 1'b1);
    check("resp_valid_after_accept", resp_valid, 1'b0);
  endtask

  // Zero-wait responder for table vectors.
  task automatic run_vec(input int idx);
    int  ar0, aw0, w0;
    bit  got;
    ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
    bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
    bus.rdata   = vecs[idx].s_rdata;
    bus.rresp   = vecs[idx].s_resp;
    bus.bresp   = vecs[idx].s_resp;
    issue(vecs[idx].wen, vecs[idx].addr, vecs[idx].wdata, vecs[idx].wstrb);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      bus.rvalid = bus.rready;
      bus.bvalid = bus.bready;
      tick();
    end
    bus.rvalid = 1'b0;
    bus.bvalid = 1'b0;
    check($sformatf("vec%0d_resp_seen", idx), got, 1'b1);
    check($sformatf("vec%0d_rdata", idx), resp_rdata, vecs[idx].exp_rdata);
    check($sformatf("vec%0d_code", idx), resp_code, vecs[idx].exp_code);
    if (vecs[idx].wen) begin
      check($sformatf("vec%0d_aw_count", idx), aw_cnt - aw0, 1);
      check($sformatf("vec%0d_w_count", idx), w_cnt - w0, 1);
      check($sformatf("vec%0d_ar_count", idx), ar_cnt - ar0, 0);
      check($sformatf("vec%0d_awaddr", idx), last_awaddr, vecs[idx].addr);
      check($sformatf("vec%0d_wdata", idx), last_wdata, vecs[idx].wdata);
      check($sformatf("vec%0d_wstrb", idx), last_wstrb, vecs[idx].wstrb);
    end else begin
      check($sformatf("vec%0d_ar_count", idx), ar_cnt - ar0, 1);
      check($sformatf("vec%0d_aw_count", idx), aw_cnt - aw0, 0);
      check($sformatf("vec%0d_araddr", idx), last_araddr, vecs[idx].addr);
    end
    accept_resp();
  endtask

  initial begin
    int  ar0, aw0, w0;
    bit  ok;
    n_vec = 0; n_fail = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    last_araddr = '0; last_awaddr = '0; last_wdata = '0; last_wstrb = '0;

    vecs[0] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF, 32'hFFFF_FFFF, 2'b00, 32'h0,         2'b00};
    vecs[2] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hA5A5_5A5A, 2'b10, 32'hA5A5_5A5A, 2'b10};
    vecs[3] = '{1'b0, 32'h1000_0008, 32'h0,         4'h0, 32'h0BAD_F00D, 2'b11, 32'h0BAD_F00D, 2'b11};
    vecs[4] = '{1'b1, 32'h2000_0000, 32'hCAFE_0001, 4'h3, 32'h1111_1111, 2'b10, 32'h0,         2'b10};
    vecs[5] = '{1'b1, 32'h2000_0004, 32'h0000_BEEF, 4'hC, 32'h2222_2222, 2'b11, 32'h0,         2'b11};

    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b0;
    bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    bus.bvalid = 1'b0; bus.bresp = '0;

    // Reset state.
    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_arvalid", bus.arvalid, 1'b0);
    check("rst_awvalid", bus.awvalid, 1'b0);
    check("rst_wvalid", bus.wvalid, 1'b0);
    check("rst_rready", bus.rready, 1'b0);
    check("rst_bready", bus.bready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_code", resp_code, 2'b00);
    rst = 1'b0;
    tick();
    check("idle_req_ready", req_ready, 1'b1);

    // Stray R/B outside their states are ignored.
    bus.rvalid = 1'b1; bus.bvalid = 1'b1;
    tick();
    tick();
    check("stray_rready", bus.rready, 1'b0);
    check("stray_bready", bus.bready, 1'b0);
    check("stray_resp_valid", resp_valid, 1'b0);
    bus.rvalid = 1'b0; bus.bvalid = 1'b0;

    // Table of single transactions.
    for (int i = 0; i < 6; i++) run_vec(i);

    // Seq 1: minimum read latency.
    bus.arready = 1'b1;
    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0);
    check("s1_t1_arvalid", bus.arvalid, 1'b1);
    check("s1_t1_araddr", bus.araddr, 32'h8000_0004);
    check("s1_t1_req_ready", req_ready, 1'b0);
    tick();
    check("s1_t2_rready", bus.rready, 1'b1);
    check("s1_t2_arvalid", bus.arvalid, 1'b0);
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 2'b00;
    tick();
    bus.rvalid = 1'b0;
    check("s1_t3_resp_valid", resp_valid, 1'b1);
    check("s1_t3_rdata", resp_rdata, 32'hDEAD_BEEF);
    check("s1_t3_code", resp_code, 2'b00);
    check("s1_t3_rready", bus.rready, 1'b0);
    accept_resp();

    // Seq 2: awready at +1, wready at +4.
    aw0 = aw_cnt; w0 = w_cnt;
    bus.awready = 1'b0; bus.wready = 1'b0;
    issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF);
    check("s2_t1_awvalid", bus.awvalid, 1'b1);
    check("s2_t1_wvalid", bus.wvalid, 1'b1);
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0;
    check("s2_t2_awvalid", bus.awvalid, 1'b0);
    check("s2_t2_wvalid", bus.wvalid, 1'b1);
    tick();
    check("s2_t3_wvalid", bus.wvalid, 1'b1);
    check("s2_t3_wdata", bus.wdata, 32'h1234_5678);
    tick();
    check("s2_t4_wvalid", bus.wvalid, 1'b1);
    check("s2_t4_bready", bus.bready, 1'b0);
    bus.wready = 1'b1;
    tick();
    bus.wready = 1'b0;
    check("s2_t5_wvalid", bus.wvalid, 1'b0);
    check("s2_t5_bready", bus.bready, 1'b1);
    bus.bvalid = 1'b1; bus.bresp = 2'b00;
    tick();
    bus.bvalid = 1'b0;
    check("s2_resp_valid", resp_valid, 1'b1);
    check("s2_code", resp_code, 2'b00);
    check("s2_rdata", resp_rdata, 32'h0);
    check("s2_aw_count", aw_cnt - aw0, 1);
    check("s2_w_count", w_cnt - w0, 1);
    accept_resp();

    // Seq 3: W before AW, B delayed 8 cycles.
    aw0 = aw_cnt; w0 = w_cnt;
    issue(1'b1, 32'h8000_0020, 32'h5555_AAAA, 4'hF);
    bus.wready = 1'b1;
    tick();
    bus.wready = 1'b0;
    check("s3_t2_wvalid", bus.wvalid, 1'b0);
    check("s3_t2_awvalid", bus.awvalid, 1'b1);
    check("s3_t2_bready", bus.bready, 1'b0);
    tick();
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0;
    check("s3_t4_awvalid", bus.awvalid, 1'b0);
    check("s3_t4_bready", bus.bready, 1'b1);
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (resp_valid || !bus.bready) ok = 1'b0;
      tick();
    end
    check("s3_wait_for_b", ok, 1'b1);
    bus.bvalid = 1'b1; bus.bresp = 2'b01;
    tick();
    bus.bvalid = 1'b0;
    check("s3_resp_valid", resp_valid, 1'b1);
    check("s3_code", resp_code, 2'b01);
    check("s3_aw_count", aw_cnt - aw0, 1);
    check("s3_w_count", w_cnt - w0, 1);
    accept_resp();

    // Seq 4: SLVERR read held under resp back-pressure.
    issue(1'b0, 32'h8000_0040, 32'h0, 4'h0);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h0F0F_1234; bus.rresp = 2'b10;
    tick();
    bus.rvalid = 1'b0; bus.rdata = 32'hFFFF_FFFF; bus.rresp = 2'b00;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!resp_valid || resp_rdata !== 32'h0F0F_1234 || resp_code !== 2'b10 || req_ready)
        ok = 1'b0;
      tick();
    end
    check("s4_held_5_cycles", ok, 1'b1);
    accept_resp();

    // Seq 5: reset while AR is stalled.
    ar0 = ar_cnt;
    bus.arready = 1'b0;
    issue(1'b0, 32'h8000_0080, 32'h0, 4'h0);
    check("s5_arvalid", bus.arvalid, 1'b1);
    tick();
    tick();
    check("s5_araddr_stable", bus.araddr, 32'h8000_0080);
    #2;
    rst = 1'b1;
    #1;
    check("s5_async_arvalid", bus.arvalid, 1'b0);
    check("s5_async_req_ready", req_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("s5_post_req_ready", req_ready, 1'b1);
    bus.arready = 1'b1;
    tick();
    check("s5_no_reissue", bus.arvalid, 1'b0);
    check("s5_ar_count", ar_cnt - ar0, 0);

    // Seq 6: misaligned read.
    ar0 = ar_cnt;
    bus.rdata = 32'h7777_7777; bus.rresp = 2'b00;
    issue(1'b0, 32'h8000_0002, 32'h0, 4'h0);
`ifdef AXI4L_MST_ALIGN_CHECK_EN
    check("s6_resp_valid", resp_valid, 1'b1);
    check("s6_code", resp_code, 2'b10);
    check("s6_rdata", resp_rdata, 32'h0);
    check("s6_arvalid", bus.arvalid, 1'b0);
    tick();
    check("s6_ar_count", ar_cnt - ar0, 0);
    accept_resp();
`else
    check("s6_arvalid", bus.arvalid, 1'b1);
    check("s6_araddr", bus.araddr, 32'h8000_0002);
    tick();
    bus.rvalid = 1'b1;
    tick();
    bus.rvalid = 1'b0;
    check("s6_resp_valid", resp_valid, 1'b1);
    check("s6_rdata", resp_rdata, 32'h7777_7777);
    check("s6_ar_count", ar_cnt - ar0, 1);
    accept_resp();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
